// File: rtl/dmem_uart_tx.sv
// dmem_uart_tx: memory-mapped 8N1 UART transmitter on the dmem request/response bus.
// DATA register (BASE+0) stores push a byte into a transmit FIFO; STATUS (BASE+4)
// loads report full/empty/active/overflow and clear the sticky overflow flag.
// Optional macro DMEM_UART_TX_SIM_PRINT_EN echoes each accepted byte with $write.
module dmem_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_fcn,
  input  logic [2:0]  req_typ,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned PW          = AW + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state;
  logic [15:0]     baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            overflow;

  logic            hit;
  logic            sel_status;
  logic            fifo_empty;
  logic            fifo_full;
  logic            tx_active;
  logic            baud_done;
  logic            pop;
  logic            data_store;
  logic            push;
  logic            drop;
  logic            status_load;
  logic [31:0]     status_word;
  logic [7:0]      head_byte;
  logic            unused_bits;

  // Request decode and FIFO/serialiser handshakes
  assign hit         = req_valid && (req_addr[31:3] == BASE_ADDR[31:3]);
  assign sel_status  = req_addr[2];
  assign fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_active   = (state != S_IDLE);
  assign baud_done   = (baud_cnt == 16'd0);
  assign pop         = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_done));
  assign data_store  = hit && req_fcn && !sel_status;
  assign push        = data_store && (!fifo_full || pop);
  assign drop        = data_store && fifo_full && !pop;
  assign status_load = hit && !req_fcn && sel_status;
  assign status_word = {28'd0, overflow, tx_active, fifo_empty, fifo_full};
  assign head_byte   = mem[rd_ptr[AW-1:0]];
  assign busy        = tx_active | ~fifo_empty;

  // Access size, upper store data and byte offset carry no meaning here
  assign unused_bits = ^{req_typ, req_data[31:8], req_addr[1:0]};

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= req_data[7:0];
    end
  end

  // FIFO pointers, wrapping naturally with one extra lap bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Sticky overflow: a drop wins over a same-cycle STATUS read clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (status_load) begin
      overflow <= 1'b0;
    end
  end

  // Single-cycle bus response; load data held between responses
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
    end else begin
      resp_valid <= hit;
      if (hit) begin
        resp_data <= status_load ? status_word : 32'd0;
      end
    end
  end

  // Serialiser: start bit, 8 data bits LSB first, stop bit; back-to-back from STOP
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      baud_cnt <= 16'd0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      txd      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            state    <= S_START;
            shreg    <= head_byte;
            txd      <= 1'b0;
            baud_cnt <= BAUD_RELOAD;
          end
        end
        S_START: begin
          if (baud_done) begin
            state    <= S_DATA;
            txd      <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
            bit_idx  <= 3'd0;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              txd   <= 1'b1;
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            if (!fifo_empty) begin
              state    <= S_START;
              shreg    <= head_byte;
              txd      <= 1'b0;
              baud_cnt <= BAUD_RELOAD;
            end else begin
              state <= S_IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

`ifdef DMEM_UART_TX_SIM_PRINT_EN
  // Console echo of every accepted byte in simulation
  always_ff @(posedge clk) begin
    if (reset && push) begin
      $write("%c", req_data[7:0]);
    end
  end
`else
  // Synthesizable build: no console echo
`endif

endmodule

// File: doc/dmem_uart_tx.md
# dmem_uart_tx

Memory-mapped 8N1 UART transmitter that responds on the core's data-memory request/response bus. A store to the data register pushes one byte into a transmit FIFO, and a serialiser shifts the byte out on `txd`. This is the synthesizable far end of the console port at `0x1000_0000`. It sits beside the data memory on the dmem bus and answers only its own address window.

## Interface
- `BASE_ADDR`, 32'h1000_0000, 8-byte-aligned register window base.
- `CLK_DIV`, 868, clocks per serial bit (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 8, transmit FIFO entries; must be a power of 2, ≥2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `req_valid`  in  1  bus request strobe.
- `req_addr`  in  32  byte address.
- `req_data`  in  32  store data; only [7:0] is used.
- `req_fcn`  in  1  1 = store, 0 = load.
- `req_typ`  in  3  access size; ignored (any size is accepted).
- `resp_valid`  out  1  response strobe.
- `resp_data`  out  32  load data.
- `txd`  out  1  serial output; idles high.
- `busy`  out  1  high while a frame is on the wire or the FIFO is non-empty.

## Operation
- **Address decode.** The block is hit when `req_valid` is high and `req_addr[31:3] == BASE_ADDR[31:3]`. Misses produce no response and no state change.
- **Register map.**
  - `BASE+0` DATA: a store pushes `req_data[7:0]`; a load returns 0.
  - `BASE+4` STATUS (load): bit0 fifo_full, bit1 fifo_empty, bit2 tx_active, bit3 overflow; bits [31:4] read 0. A store to STATUS is accepted and ignored.
- **Overflow.** A DATA store while the FIFO is full drops the byte and sets the sticky overflow flag. A STATUS load returns the current flag value and clears it in the same cycle. If an overflow and a STATUS load occur in the same cycle, overflow stays set.
- **FIFO.** Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. If a push and a pop occur in the same cycle while the FIFO is full, both take effect and the byte is not dropped. A pop occurs only on the IDLE→START or STOP→START transition.
- **Serialiser FSM.** States are IDLE, START, DATA, STOP.
  - IDLE→START when the FIFO is non-empty. This transition pops the byte into the shift register and sets `txd=0`.
  - START→DATA after CLK_DIV cycles.
  - DATA shifts LSB first, holding each bit for CLK_DIV cycles. After 8 bits it goes to STOP with `txd=1`.
  - STOP lasts CLK_DIV cycles. It then goes to START if the FIFO is non-empty, with no idle gap; otherwise it goes to IDLE.
- **Baud counter.** Loads CLK_DIV-1 on each state or bit entry and decrements to 0. The 16-bit width is fixed.
- **`busy`.** Equals `tx_active | ~fifo_empty`, where tx_active is "state != IDLE".
- **Reset mid-frame.** The frame is aborted immediately and `txd` returns high. The FIFO is flushed and the overflow flag is cleared.

## Timing
- **Reset values.** `txd`=1, `resp_valid`=0, `resp_data`=0, `busy`=0; FSM in IDLE; FIFO empty; overflow cleared.
- **Response latency.** `resp_valid` is high exactly 1 cycle after a hit, for 1 cycle. Back-to-back hits give back-to-back responses.
- **Load data.** `resp_data` is registered with the response. It holds its value between responses and is 0 for DATA loads and stores.
- **Status sampling.** STATUS reflects the state before the same-cycle push or pop.
- **Store to first start bit.** For a store at edge N into an empty FIFO with an idle FSM:
  - the FIFO is non-empty after edge N;
  - the FSM enters START at edge N+1;
  - `txd` falls at N+1.
- **Frame length.** A full frame is exactly 10·CLK_DIV cycles.

## Configuration
- `DMEM_UART_TX_SIM_PRINT_EN` defined: every accepted DATA push also executes `$write("%c", byte)` for console echo in simulation. Serial behaviour is identical.
- Not defined: no simulation-only constructs; the block is fully synthesizable.

## Test plan
- **Single byte.** CLK_DIV=4; store 0x55 to 0x1000_0000.
  - `resp_valid` is high 1 cycle later.
  - `txd` = 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles, starting 1 cycle after the store edge.
  - `busy` falls 40 cycles after `txd` falls.
- **Back-to-back frames.** Store 0xA3 then 0x0F on consecutive cycles. The two frames are contiguous with no idle cycles between them, 80 cycles total.
- **FIFO full and overflow.** FIFO_DEPTH=8, CLK_DIV=4.
  - Store 10 bytes in 10 cycles: 1 is popped immediately, 8 are queued, 1 is dropped.
  - A STATUS load reads 0x0D (full, active, overflow).
  - A second STATUS load reads overflow=0.
  - Exactly 9 frames are transmitted.
- **Address miss.** A load from 0x1000_0008 and a store to 0x2000_0000 produce no `resp_valid`, and `txd` stays high.
- **Reset mid-frame.** Drive `reset` low during bit 3 of a frame.
  - `txd`=1 and `busy`=0 one edge later.
  - The FIFO reads empty afterwards (STATUS = 0x02).
